// File: rtl/alu_mdu_cu_pkg.sv
// alu_mdu_cu_pkg: shared codes for the execute-stage ALU control unit.
// Holds main-decoder ALU classes, ALU operation codes, M-extension funct
// fields, MDU sequencer states and the RV32I ALU-control decode function.
package alu_mdu_cu_pkg;

    // Main-decoder ALU classes
    localparam logic [2:0] R_TYPE = 3'd0;
    localparam logic [2:0] I_TYPE = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] STORE  = 3'd3;
    localparam logic [2:0] BRANCH = 3'd4;
    localparam logic [2:0] JUMP   = 3'd5;
    localparam logic [2:0] U_TYPE = 3'd6;
    localparam logic [2:0] NOP    = 3'd7;

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_LT   = 4'd8;
    localparam logic [3:0] ALU_LTU  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NE   = 4'd11;
    localparam logic [3:0] ALU_GT   = 4'd12;
    localparam logic [3:0] ALU_GTU  = 4'd13;
    localparam logic [3:0] ALU_PC4  = 4'd14;

    // M extension
    localparam logic [6:0] M_FUNCT7  = 7'b0000001;
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // RV32I ALU control decode (non-M instructions)
    function automatic logic [3:0] alu_decode(input logic [2:0] aluop,
                                              input logic [2:0] funct3,
                                              input logic [6:0] funct7);
        logic [3:0] ctl;
        ctl = 4'b0000;
        case (aluop)
            LOAD, STORE, U_TYPE, NOP: ctl = ALU_ADD;
            JUMP:                     ctl = ALU_PC4;
            R_TYPE, I_TYPE: begin
                case (funct3)
                    3'b000: ctl = (aluop == R_TYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001: ctl = ALU_SLL;
                    3'b010: ctl = ALU_LT;
                    3'b011: ctl = ALU_LTU;
                    3'b100: ctl = ALU_XOR;
                    3'b101: ctl = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: ctl = ALU_OR;
                    default: ctl = ALU_AND;
                endcase
            end
            BRANCH: begin
                case (funct3)
                    3'b000:  ctl = ALU_EQ;
                    3'b001:  ctl = ALU_NE;
                    3'b100:  ctl = ALU_LT;
                    3'b101:  ctl = ALU_GT;
                    3'b110:  ctl = ALU_LTU;
                    3'b111:  ctl = ALU_GTU;
                    default: ctl = 4'b0000;
                endcase
            end
            default: ctl = 4'b0000;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_mdu_cu_mdu_iter_core.sv
// mdu_iter_core: shared 2*XLEN accumulator with add/subtract step datapath.
// mode_i=0: shift-add multiply, {hi,lo} = {partial product, multiplier}.
// mode_i=1: restoring divide, {hi,lo} = {partial remainder, quotient}.
// acc_nxt_o is the accumulator value after the step in progress, so the
// caller can capture the final result in the same cycle as the last step.
module mdu_iter_core
    import alu_mdu_cu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              mode_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_nxt_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   diff;

    // One iteration of the selected algorithm
    always_comb begin
        sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        // Remainder can reach 2^XLEN after the shift, so keep one extra bit
        rem_sh = acc_q[2*XLEN-1:XLEN-1];
        diff   = {1'b0, rem_sh} - {2'b00, b_q};
        if (mode_i) begin
            if (diff[XLEN+1])
                acc_nxt_o = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            else
                acc_nxt_o = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            if (acc_q[0])
                acc_nxt_o = {sum, acc_q[XLEN-1:1]};
            else
                acc_nxt_o = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    // Load operands or advance one step
    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, a_i};
            b_d   = b_i;
        end else if (step_i) begin
            acc_d = acc_nxt_o;
        end
    end

    // Accumulator and operand registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

endmodule

// File: rtl/alu_mdu_cu.sv
// alu_mdu_cu: execute-stage ALU control unit with multi-cycle M-extension
// sequencer. Non-M ops decode straight to alu_control; M ops stall the
// pipeline while mdu_iter_core iterates, then pulse mdu_done with the result.
// Build option: MDU_FAST_MUL_EN selects a single-cycle multiplier for MUL*.
//
// state   | meaning
// IDLE    | no M op in flight; detect and latch a new one
// MUL     | shift-add multiply, one bit per cycle
// DIV     | restoring divide, one bit per cycle
// DONE    | result valid, mdu_done pulses, pipeline released
module alu_mdu_cu
    import alu_mdu_cu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [2:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      alu_control,
    output logic            mdu_sel,
    output logic [XLEN-1:0] mdu_result,
    output logic            mdu_done,
    output logic            stall_o
);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [2:0]        f3_q, f3_d;
    logic              sa_q, sa_d, sb_q, sb_d;

    logic              m_op;
    logic              signed_a, signed_b, sa_in, sb_in;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] fast_prod;
    logic              load, step, stall, done;

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
    assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`else
    localparam bit FAST_MUL = 1'b0;
    assign fast_prod = '0;
`endif

    // Sign fix-up of the unsigned magnitude result
    function automatic logic [XLEN-1:0] fixup(input logic [2:0] f3,
                                              input logic sa,
                                              input logic sb,
                                              input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quot, rem;
        prod = (sa ^ sb) ? -acc : acc;
        quot = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!f3[2])
            return (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            return f3[1] ? rem : quot;
    endfunction

    assign m_op     = valid_i && (aluop == R_TYPE) && (funct7 == M_FUNCT7);
    assign signed_a = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    assign signed_b = signed_a && (funct3 != F3_MULHSU);
    assign sa_in    = signed_a && op_a[XLEN-1];
    assign sb_in    = signed_b && op_b[XLEN-1];
    assign abs_a    = sa_in ? -op_a : op_a;
    assign abs_b    = sb_in ? -op_b : op_b;

    // Divide corner cases resolve without iterating
    assign div_zero    = (op_b == '0);
    assign div_ovf     = signed_b && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign special_res = div_zero ? (funct3[1] ? op_a : '1)
                                  : (funct3[1] ? '0 : op_a);

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .step_i    (step),
        .mode_i    (f3_q[2]),
        .a_i       (abs_a),
        .b_i       (abs_b),
        .acc_nxt_o (acc_nxt)
    );

    // Sequencer next-state and control outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        f3_d    = f3_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        load    = 1'b0;
        step    = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m_op) begin
                        stall = 1'b1;
                        load  = 1'b1;
                        f3_d  = funct3;
                        sa_d  = sa_in;
                        sb_d  = sb_in;
                        cnt_d = CNT_W'(XLEN - 1);
                        if (funct3[2] && (div_zero || div_ovf)) begin
                            res_d   = special_res;
                            state_d = ST_DONE;
                        end else if (FAST_MUL && !funct3[2]) begin
                            res_d   = fixup(funct3, sa_in, sb_in, fast_prod);
                            state_d = ST_DONE;
                        end else begin
                            state_d = funct3[2] ? ST_DIV : ST_MUL;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    stall = 1'b1;
                    step  = 1'b1;
                    if (cnt_q == '0) begin
                        res_d   = fixup(f3_q, sa_q, sb_q, acc_nxt);
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            f3_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            f3_q    <= f3_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

    // Reset also masks the combinational pipeline controls
    assign alu_control = m_op ? 4'b0000 : alu_decode(aluop, funct3, funct7);
    assign mdu_sel     = m_op && rst_n;
    assign stall_o     = stall && rst_n;
    assign mdu_done    = done;
    assign mdu_result  = res_q;

endmodule

// File: tb/tb_alu_mdu_cu.sv
// tb_alu_mdu_cu: directed table-driven bench for alu_mdu_cu (XLEN=32).
module tb_alu_mdu_cu;
    import alu_mdu_cu_pkg::*;

    localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  aluop = NOP;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [3:0]  alu_control;
    logic        mdu_sel;
    logic [31:0] mdu_result;
    logic        mdu_done;
    logic        stall_o;

    alu_mdu_cu #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .flush_i     (flush_i),
        .aluop       (aluop),
        .funct3      (funct3),
        .funct7      (funct7),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_control (alu_control),
        .mdu_sel     (mdu_sel),
        .mdu_result  (mdu_result),
        .mdu_done    (mdu_done),
        .stall_o     (stall_o)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        string       nm;
    } mvec_t;

    typedef struct {
        logic [2:0] aluop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] ctl;
        string      nm;
    } dvec_t;

    // Present an M op and follow it to mdu_done; returns the cycle of the pulse
    task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int exp_lat, input string nm,
                           output int done_at);
        int stalls;
        bit seen;
        stalls  = 0;
        seen    = 1'b0;
        done_at = -1;
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b0; aluop = R_TYPE; funct7 = M_FUNCT7;
        funct3 = f3; op_a = a; op_b = b;
        #1;
        chk($sformatf("%s alu_control", nm), 32'(alu_control), 32'd0);
        chk($sformatf("%s mdu_sel", nm), 32'(mdu_sel), 32'd1);
        for (int cyc = 0; cyc <= XLEN + 8 && !seen; cyc++) begin
            if (cyc != 0) begin
                @(negedge clk);
                #1;
            end
            if (stall_o) stalls++;
            if (mdu_done) begin
                seen    = 1'b1;
                done_at = cyc_cnt;
                chk($sformatf("%s result", nm), mdu_result, exp_res);
                chk($sformatf("%s done_cycle", nm), 32'(cyc), 32'(exp_lat));
                chk($sformatf("%s stall_cycles", nm), 32'(stalls), 32'(exp_lat));
            end
        end
        if (!seen) chk($sformatf("%s done_timeout", nm), 32'd0, 32'd1);
    endtask

    mvec_t mv[$];
    dvec_t dv[$];
    int d1, d2;
    logic [31:0] last_res;
    bit bad;

    initial begin
        mv.push_back('{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "MUL"});
        mv.push_back('{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "MULHU"});
        mv.push_back('{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT, "MULH"});
        mv.push_back('{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT, "MULHSU"});
        mv.push_back('{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, "MULH_min"});
        mv.push_back('{F3_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MUL_LAT, "MULHSU_min"});
        mv.push_back('{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, "DIV"});
        mv.push_back('{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, "REM"});
        mv.push_back('{F3_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT, "DIVU"});
        mv.push_back('{F3_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT, "REMU"});
        mv.push_back('{F3_DIV,    32'h80000000, 32'd3,        32'hD5555556, DIV_LAT, "DIV_min3"});
        mv.push_back('{F3_REM,    32'h80000000, 32'd3,        32'hFFFFFFFE, DIV_LAT, "REM_min3"});
        mv.push_back('{F3_DIVU,   32'hFFFFFFFF, 32'h80000001, 32'd1,        DIV_LAT, "DIVU_big"});
        mv.push_back('{F3_REMU,   32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, DIV_LAT, "REMU_big"});
        mv.push_back('{F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,       "DIVU_by0"});
        mv.push_back('{F3_REMU,   32'd5,        32'd0,        32'd5,        1,       "REMU_by0"});
        mv.push_back('{F3_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,       "REM_by0"});
        mv.push_back('{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,       "DIV_ovf"});
        mv.push_back('{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,       "REM_ovf"});

        dv.push_back('{R_TYPE, 3'b000, 7'b0100000, ALU_SUB, "R_SUB"});
        dv.push_back('{R_TYPE, 3'b000, 7'b0000000, ALU_ADD, "R_ADD"});
        dv.push_back('{R_TYPE, 3'b101, 7'b0100000, ALU_SRA, "R_SRA"});
        dv.push_back('{R_TYPE, 3'b111, 7'b0000000, ALU_AND, "R_AND"});
        dv.push_back('{I_TYPE, 3'b000, 7'b0100000, ALU_ADD, "I_ADDI"});
        dv.push_back('{I_TYPE, 3'b010, 7'b0000000, ALU_LT,  "I_SLTI"});
        dv.push_back('{I_TYPE, 3'b101, 7'b0000000, ALU_SRL, "I_SRLI"});
        dv.push_back('{BRANCH, 3'b001, 7'b0000000, ALU_NE,  "B_BNE"});
        dv.push_back('{BRANCH, 3'b101, 7'b0000000, ALU_GT,  "B_BGE"});
        dv.push_back('{BRANCH, 3'b111, 7'b0000000, ALU_GTU, "B_BGEU"});
        dv.push_back('{JUMP,   3'b000, 7'b0000000, ALU_PC4, "JUMP"});
        dv.push_back('{LOAD,   3'b010, 7'b0000000, ALU_ADD, "LOAD"});
        dv.push_back('{U_TYPE, 3'b000, 7'b0000000, ALU_ADD, "U_TYPE"});

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset mdu_result", mdu_result, 32'd0);
        chk("reset mdu_done", 32'(mdu_done), 32'd0);
        chk("reset stall_o", 32'(stall_o), 32'd0);
        chk("reset mdu_sel", 32'(mdu_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-M decode
        foreach (dv[i]) begin
            @(negedge clk);
            valid_i = 1'b1; aluop = dv[i].aluop; funct3 = dv[i].f3; funct7 = dv[i].f7;
            #1;
            chk($sformatf("%s alu_control", dv[i].nm), 32'(alu_control), 32'(dv[i].ctl));
            chk($sformatf("%s stall", dv[i].nm), 32'(stall_o), 32'd0);
            chk($sformatf("%s mdu_sel", dv[i].nm), 32'(mdu_sel), 32'd0);
        end

        // M ops, each followed by an idle cycle to confirm a single done pulse
        foreach (mv[i]) begin
            run_mop(mv[i].f3, mv[i].a, mv[i].b, mv[i].res, mv[i].lat, mv[i].nm, d1);
            @(negedge clk);
            valid_i = 1'b0;
            #1;
            chk($sformatf("%s done_oneshot", mv[i].nm), 32'(mdu_done), 32'd0);
            chk($sformatf("%s idle_stall", mv[i].nm), 32'(stall_o), 32'd0);
        end
        last_res = mv[mv.size()-1].res;

        // valid_i low: an M encoding must not start
        @(negedge clk);
        valid_i = 1'b0; aluop = R_TYPE; funct7 = M_FUNCT7; funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd3;
        #1;
        chk("novalid stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        #1;
        chk("novalid done", 32'(mdu_done), 32'd0);

        // Flush in the middle of a divide
        @(negedge clk);
        valid_i = 1'b1; aluop = R_TYPE; funct7 = M_FUNCT7; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7;
        repeat (10) @(negedge clk);
        #1;
        chk("flush pre_stall", 32'(stall_o), 32'd1);
        flush_i = 1'b1;
        #1;
        chk("flush stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0; funct7 = 7'd0; funct3 = 3'b000;
        #1;
        chk("flush add_ctl", 32'(alu_control), 32'(ALU_ADD));
        chk("flush add_stall", 32'(stall_o), 32'd0);
        chk("flush add_sel", 32'(mdu_sel), 32'd0);
        chk("flush result_held", mdu_result, last_res);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (mdu_done || stall_o) bad = 1'b1;
        end
        chk("flush no_done", 32'(bad), 32'd0);

        // Reset in the middle of a divide
        @(negedge clk);
        valid_i = 1'b1; aluop = R_TYPE; funct7 = M_FUNCT7; funct3 = F3_DIV; op_a = 32'hFFFFFFF9; op_b = 32'd2;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midreset result", mdu_result, 32'd0);
        chk("midreset done", 32'(mdu_done), 32'd0);
        chk("midreset stall", 32'(stall_o), 32'd0);
        chk("midreset sel", 32'(mdu_sel), 32'd0);
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_mop(F3_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, "post_reset DIVU", d1);

        // Back-to-back multiplies
        run_mop(F3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "b2b MUL1", d1);
        run_mop(F3_MUL, 32'd3, 32'd5, 32'd15, MUL_LAT, "b2b MUL2", d2);
        chk("b2b spacing", 32'(d2 - d1), 32'(MUL_LAT + 1));
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("b2b done_oneshot", 32'(mdu_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1, "timeout");
    end

endmodule
